// File: rtl/mult_arbiter_pkg.sv
// mult_arbiter_pkg: shared CPU types and defaults for the multiplier arbiter
package mult_arbiter_pkg;
  localparam int unsigned WATCHDOG_DEF = 40;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_e;
endpackage

// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin arbiter sharing one multiplier between two requesters
module mult_arbiter
  import mult_arbiter_pkg::*;
#(
  parameter int unsigned WATCHDOG = WATCHDOG_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] op1_0,
  input  logic [31:0] op2_0,
  input  logic [31:0] op1_1,
  input  logic [31:0] op2_1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [63:0] product,
  output logic        err,
  output logic        busy,
  output logic        mult_begin,
  output logic [31:0] mult_op1,
  output logic [31:0] mult_op2,
  input  logic [63:0] mult_product,
  input  logic        mult_end
);
  localparam int WDW = $clog2(WATCHDOG + 1);
  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             ptr_q, ptr_d;
  logic [WDW-1:0]   wd_q, wd_d;
  logic [31:0]      op1_q, op1_d, op2_q, op2_d;
  logic [63:0]      product_q, product_d;
  logic             err_q, err_d;
  logic             win;
  logic [WDW-1:0]   wd_inc;
  // Arbitration, operand capture, watchdog and result capture
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    wd_d      = wd_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    product_d = product_q;
    err_d     = err_q;
    win       = (req0 & req1) ? ptr_q : req1;
    wd_inc    = wd_q + WDW'(1);
    case (state_q)
      IDLE: if (req0 | req1) begin
        state_d = LAUNCH;
        owner_d = win;
        op1_d   = win ? op1_1 : op1_0;
        op2_d   = win ? op2_1 : op2_0;
      end
      LAUNCH: begin
        state_d = WAIT;
        wd_d    = '0;
      end
      WAIT: if (mult_end) begin
        state_d   = DONE;
        product_d = mult_product;
        err_d     = 1'b0;
      end else if (wd_inc == WDW'(WATCHDOG)) begin
        state_d   = DONE;
        product_d = '0;
        err_d     = 1'b1;
      end else begin
        wd_d = wd_inc;
      end
      DONE: begin
        state_d = IDLE;
        ptr_d   = ~owner_q;
      end
      default: state_d = IDLE;
    endcase
  end
  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      ptr_q     <= 1'b0;
      wd_q      <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      product_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      wd_q      <= wd_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      product_q <= product_d;
      err_q     <= err_d;
    end
  end
  assign gnt0       = (state_q == LAUNCH) & ~owner_q;
  assign gnt1       = (state_q == LAUNCH) & owner_q;
  assign done0      = (state_q == DONE) & ~owner_q;
  assign done1      = (state_q == DONE) & owner_q;
  assign mult_begin = state_q == LAUNCH;
  assign busy       = state_q != IDLE;
  assign mult_op1   = op1_q;
  assign mult_op2   = op2_q;
  assign product    = product_q;
  assign err        = err_q;
endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: directed self-checking bench for mult_arbiter
module tb_mult_arbiter;
  logic        clk = 0, resetn = 0, req0 = 0, req1 = 0;
  logic [31:0] op1_0 = 0, op2_0 = 0, op1_1 = 0, op2_1 = 0;
  logic        gnt0, gnt1, done0, done1, err, busy, mult_begin, mult_end;
  logic [63:0] product, mult_product;
  logic [31:0] mult_op1, mult_op2;
  logic        me_q = 0, me_force = 0;
  int          lat = 0, cnt = 0;
  int          n_cmp = 0, n_fail = 0;
  int          nbeg = 0, ndone = 0, ovl = 0;
  int          order[$];

  mult_arbiter dut (
    .clk(clk), .resetn(resetn), .req0(req0), .req1(req1),
    .op1_0(op1_0), .op2_0(op2_0), .op1_1(op1_1), .op2_1(op2_1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .product(product), .err(err), .busy(busy), .mult_begin(mult_begin),
    .mult_op1(mult_op1), .mult_op2(mult_op2),
    .mult_product(mult_product), .mult_end(mult_end)
  );

  always #5 clk = ~clk;

  // Model multiplier: mult_end rises lat edges after the edge that samples mult_begin
  assign mult_product = {32'b0, mult_op1} * {32'b0, mult_op2};
  assign mult_end = me_q | me_force;
  always @(posedge clk) begin
    if (!resetn) cnt <= 0;
    else if (mult_begin && lat > 0) cnt <= lat;
    else if (cnt > 0) cnt <= cnt - 1;
    me_q <= resetn && cnt == 1;
  end

  always @(negedge clk) begin
    if (gnt0) order.push_back(0);
    if (gnt1) order.push_back(1);
    if (mult_begin) nbeg++;
    if (done0 | done1) ndone++;
    if ((gnt0 & gnt1) | (done0 & done1)) ovl++;
  end

  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (done0 | done1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    resetn = 0;
    @(negedge clk);
    resetn = 1;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if ({busy, gnt0, gnt1, done0, done1, err, mult_begin} !== 7'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 0000000", {busy, gnt0, gnt1, done0, done1, err, mult_begin}); end
    n_cmp++; if (product !== 64'd0) begin n_fail++; $display("FAIL reset_product: got %0d expected 0", product); end
    n_cmp++; if ({mult_op1, mult_op2} !== 64'd0) begin n_fail++; $display("FAIL reset_ops: got %h expected 0", {mult_op1, mult_op2}); end
    repeat (2) @(negedge clk);
    resetn = 1;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single();
    int cyc, b;
    @(negedge clk);
    op1_0 = 3; op2_0 = 3; req0 = 1; lat = 4; b = nbeg;
    @(negedge clk);
    n_cmp++; if ({gnt0, gnt1, mult_begin} !== 3'b101) begin n_fail++; $display("FAIL single_gnt: got %b expected 101", {gnt0, gnt1, mult_begin}); end
    wait_done(cyc);
    n_cmp++; if (cyc != 6) begin n_fail++; $display("FAIL single_latency: got %0d expected 6", cyc); end
    n_cmp++; if ({done0, done1, err} !== 3'b100) begin n_fail++; $display("FAIL single_done: got %b expected 100", {done0, done1, err}); end
    n_cmp++; if (product !== 64'd9) begin n_fail++; $display("FAIL single_product: got %0d expected 9", product); end
    req0 = 0;
    @(negedge clk);
    n_cmp++; if (nbeg - b != 1) begin n_fail++; $display("FAIL single_begin_count: got %0d expected 1", nbeg - b); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: got %b expected 0", busy); end
  endtask

  task automatic test_operand_hold();
    int cyc;
    op1_0 = 3; op2_0 = 5; req0 = 1; lat = 2;
    @(negedge clk);
    n_cmp++; if ({gnt0, gnt1} !== 2'b10) begin n_fail++; $display("FAIL hold_lone_gnt: got %b expected 10", {gnt0, gnt1}); end
    op1_0 = 7;
    @(negedge clk);
    n_cmp++; if (mult_op1 !== 32'd3) begin n_fail++; $display("FAIL hold_op1: got %0d expected 3", mult_op1); end
    wait_done(cyc);
    n_cmp++; if (product !== 64'd15) begin n_fail++; $display("FAIL hold_product: got %0d expected 15", product); end
    req0 = 0;
    @(negedge clk);
  endtask

  task automatic test_both();
    int cyc, g, o;
    apply_reset();
    g = order.size(); o = ovl;
    op1_0 = 2; op2_0 = 12; op1_1 = 3; op2_1 = 25; req0 = 1; req1 = 1; lat = 2;
    wait_done(cyc);
    n_cmp++; if (cyc != 5) begin n_fail++; $display("FAIL both_lat0: got %0d expected 5", cyc); end
    n_cmp++; if ({done0, done1} !== 2'b10) begin n_fail++; $display("FAIL both_first: got %b expected 10", {done0, done1}); end
    n_cmp++; if (product !== 64'd24) begin n_fail++; $display("FAIL both_product0: got %0d expected 24", product); end
    req0 = 0;
    wait_done(cyc);
    n_cmp++; if (cyc != 6) begin n_fail++; $display("FAIL both_lat1: got %0d expected 6", cyc); end
    n_cmp++; if ({done0, done1} !== 2'b01) begin n_fail++; $display("FAIL both_second: got %b expected 01", {done0, done1}); end
    n_cmp++; if (product !== 64'd75) begin n_fail++; $display("FAIL both_product1: got %0d expected 75", product); end
    req1 = 0;
    repeat (2) @(negedge clk);
    n_cmp++; if (order.size() - g != 2) begin n_fail++; $display("FAIL both_gnt_count: got %0d expected 2", order.size() - g); end
    n_cmp++; if (ovl != o) begin n_fail++; $display("FAIL both_overlap: got %0d expected %0d", ovl, o); end
  endtask

  task automatic test_back_to_back();
    int cyc, g;
    g = order.size();
    op1_0 = 4; op2_0 = 5; op1_1 = 6; op2_1 = 7; req0 = 1; req1 = 1; lat = 1;
    for (int k = 0; k < 6; k++) begin
      wait_done(cyc);
      n_cmp++; if ({done0, done1} !== ((k % 2) ? 2'b01 : 2'b10)) begin n_fail++; $display("FAIL rr_done_%0d: got %b expected %b", k, {done0, done1}, (k % 2) ? 2'b01 : 2'b10); end
      n_cmp++; if (product !== ((k % 2) ? 64'd42 : 64'd20)) begin n_fail++; $display("FAIL rr_product_%0d: got %0d expected %0d", k, product, (k % 2) ? 42 : 20); end
    end
    req0 = 0; req1 = 0;
    repeat (2) @(negedge clk);
    n_cmp++; if (order.size() - g != 6) begin n_fail++; $display("FAIL rr_gnt_count: got %0d expected 6", order.size() - g); end
    for (int k = 0; k < 6 && g + k < order.size(); k++) begin
      n_cmp++; if (order[g + k] != k % 2) begin n_fail++; $display("FAIL rr_order_%0d: got %0d expected %0d", k, order[g + k], k % 2); end
    end
    n_cmp++; if (ovl != 0) begin n_fail++; $display("FAIL rr_overlap: got %0d expected 0", ovl); end
  endtask

  task automatic test_watchdog();
    int cyc;
    op1_0 = 5; op2_0 = 6; req0 = 1; lat = 0;
    wait_done(cyc);
    n_cmp++; if (cyc != 42) begin n_fail++; $display("FAIL wd_latency: got %0d expected 42", cyc); end
    n_cmp++; if ({done0, err} !== 2'b11) begin n_fail++; $display("FAIL wd_err: got %b expected 11", {done0, err}); end
    n_cmp++; if (product !== 64'd0) begin n_fail++; $display("FAIL wd_product: got %0d expected 0", product); end
    req0 = 0;
    @(negedge clk);
    req0 = 1; lat = 3;
    wait_done(cyc);
    n_cmp++; if (cyc != 6) begin n_fail++; $display("FAIL wd_recover_lat: got %0d expected 6", cyc); end
    n_cmp++; if ({done0, err} !== 2'b10) begin n_fail++; $display("FAIL wd_recover_err: got %b expected 10", {done0, err}); end
    n_cmp++; if (product !== 64'd30) begin n_fail++; $display("FAIL wd_recover_product: got %0d expected 30", product); end
    req0 = 0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int d;
    op1_0 = 9; op2_0 = 9; req0 = 1; lat = 0;
    repeat (5) @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_before: got %b expected 1", busy); end
    d = ndone;
    resetn = 0;
    #1;
    n_cmp++; if ({busy, gnt0, gnt1, done0, done1, err, mult_begin} !== 7'b0) begin n_fail++; $display("FAIL rmid_ctrl: got %b expected 0000000", {busy, gnt0, gnt1, done0, done1, err, mult_begin}); end
    n_cmp++; if ({product, mult_op1, mult_op2} !== 128'd0) begin n_fail++; $display("FAIL rmid_data: got %h expected 0", {product, mult_op1, mult_op2}); end
    @(negedge clk);
    resetn = 1; req0 = 0; me_force = 1;
    @(negedge clk);
    me_force = 0;
    repeat (3) @(negedge clk);
    n_cmp++; if (ndone != d) begin n_fail++; $display("FAIL rmid_no_done: got %0d expected %0d", ndone, d); end
    n_cmp++; if ({busy, product} !== 65'd0) begin n_fail++; $display("FAIL rmid_idle: got %h expected 0", {busy, product}); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_operand_hold();
    test_both();
    test_back_to_back();
    test_watchdog();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
